// File: rtl/usreg_pkg.sv
// Shared constants for the universal shift register: mode codes, frame FSM encoding,
// and the frame counter width helper.
package usreg_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
  localparam logic [2:0] MODE_ROTR = 3'b100;
  localparam logic [2:0] MODE_ROTL = 3'b101;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // A two-bit register still needs one counter bit.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/usreg_frame_fsm.sv
// Frame engine: IDLE -> SHIFT (WIDTH shifts) -> DONE -> IDLE; emits load/shift strobes.
// Latency: strobes are combinational from state/en/start; state advances one step per enabled edge.
// Backpressure: none; en low freezes state and counter, and starts outside IDLE are dropped.
module usreg_frame_fsm
  import usreg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic start,
  output logic load,
  output logic shift,
  output logic busy,
  output logic done
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;

  always_comb begin
    load  = en && (state == ST_IDLE) && start;
    shift = en && (state == ST_SHIFT);
    busy  = (state != ST_IDLE);
    done  = (state == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else if (en) begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_SHIFT;
            cnt   <= '0;
          end
        end
        ST_SHIFT: begin
          // Final shift happens on the LAST count; counter stops there instead of wrapping.
          if (cnt == LAST) state <= ST_DONE;
          else             cnt   <= cnt + CW'(1);
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/usreg_ctrl.sv
// Universal shift register with serial frame engine; rotate modes only with USREG_ROTATE_EN.
// Latency: out updates on the enabled edge; a frame shows pin LSB-first over WIDTH cycles after start.
// Backpressure: none; en low stalls everything, start while busy is dropped.
module usreg_ctrl
  import usreg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             sinp_msb,
  input  logic             sinp_lsb,
  input  logic [WIDTH-1:0] pin,
  input  logic             start,
  output logic [WIDTH-1:0] out,
  output logic             sout_lsb,
  output logic             sout_msb,
  output logic             busy,
  output logic             done
);

  logic [WIDTH-1:0] q;
  logic             load;
  logic             shift;

  usreg_frame_fsm #(.WIDTH(WIDTH)) u_fsm (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .start (start),
    .load  (load),
    .shift (shift),
    .busy  (busy),
    .done  (done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (en) begin
      if (load) begin
        q <= pin;
      end else if (shift) begin
        q <= {sinp_msb, q[WIDTH-1:1]};
      end else if (!busy) begin
        // Manual modes only act in IDLE; DONE holds q.
        case (mode)
          MODE_SHR:  q <= {sinp_msb, q[WIDTH-1:1]};
          MODE_SHL:  q <= {q[WIDTH-2:0], sinp_lsb};
          MODE_LOAD: q <= pin;
`ifdef USREG_ROTATE_EN
          MODE_ROTR: q <= {q[0], q[WIDTH-1:1]};
          MODE_ROTL: q <= {q[WIDTH-2:0], q[WIDTH-1]};
          MODE_HOLD: q <= q;
`else
          MODE_HOLD, MODE_ROTR, MODE_ROTL: q <= q;
`endif
          default:   q <= q;
        endcase
      end
    end
  end

  assign out      = q;
  assign sout_lsb = q[0];
  assign sout_msb = q[WIDTH-1];

endmodule
